iir_deemph: RTL and testbench

IIR_DEEMPH -- requirements
Module: iir_deemph

---
 rtl/iir_deemph.sv | 166 ++++++++++++++++
 tb/tb_iir_deemph.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_deemph.sv
// iir_deemph -- first-order IIR de-emphasis filter between two FIFOs.
//
//   y[n] = deq(X_COEFF0*x[n] + X_COEFF1*x[n-1]) + deq(Y_COEFF1*y[n-1])
//   deq(v) = v >>> BITS (arithmetic shift, rounds toward -inf)
//
// One sample is processed per READ -> COMPUTE -> WRITE pass, so the peak
// rate is one sample every three clocks. History (x[n-1], y[n-1]) advances
// only when the result is actually pushed downstream.
//
// Build option:
//   IIR_DEEMPH_SATURATE_EN  defined   -> out-of-range sums clamp to the
//                                        signed DATA_WIDTH limits
//                           undefined -> sums wrap to the low DATA_WIDTH bits
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   x_in         head word of the upstream FIFO
//   x_in_rd_en   pop strobe to the upstream FIFO
//   x_in_empty   upstream FIFO empty
//   y_out        filtered sample (registered)
//   y_out_wr_en  push strobe to the downstream FIFO
//   y_out_full   downstream FIFO full
module iir_deemph #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 BITS       = 10,
    parameter logic signed [31:0] X_COEFF0   = 178,
    parameter logic signed [31:0] X_COEFF1   = 178,
    parameter logic signed [31:0] Y_COEFF1   = 667
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  x_in_rd_en,
    input  logic                  x_in_empty,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_wr_en,
    input  logic                  y_out_full
);

    localparam int PW = 2 * DATA_WIDTH;

    // Coefficients sign-extended to the product width.
    localparam logic signed [PW-1:0] C_X0 = PW'(X_COEFF0);
    localparam logic signed [PW-1:0] C_X1 = PW'(X_COEFF1);
    localparam logic signed [PW-1:0] C_Y1 = PW'(Y_COEFF1);

    typedef enum logic [1:0] {
        READ,
        COMPUTE,
        WRITE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DATA_WIDTH-1:0] x_n;
    logic signed [DATA_WIDTH-1:0] x_n1;
    logic signed [DATA_WIDTH-1:0] y_n1;

    logic signed [PW-1:0]         ff_sum;
    logic signed [PW-1:0]         fb_prod;
    logic signed [PW-1:0]         ff_q;
    logic signed [PW-1:0]         fb_q;
    logic        [DATA_WIDTH-1:0] y_calc;
`ifdef IIR_DEEMPH_SATURATE_EN
    logic signed [PW:0]           sum_ext;
    logic        [PW-DATA_WIDTH+1:0] sum_hi;
`endif

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        ff_sum  = C_X0 * PW'(x_n) + C_X1 * PW'(x_n1);
        fb_prod = C_Y1 * PW'(y_n1);
        ff_q    = ff_sum >>> BITS;
        fb_q    = fb_prod >>> BITS;
`ifdef IIR_DEEMPH_SATURATE_EN
        // One guard bit keeps the sum of two full-width terms exact; the
        // result fits only if every bit from DATA_WIDTH-1 upward agrees.
        sum_ext = {ff_q[PW-1], ff_q} + {fb_q[PW-1], fb_q};
        sum_hi  = sum_ext[PW:DATA_WIDTH-1];
        if ((|sum_hi) && !(&sum_hi)) begin
            y_calc = sum_ext[PW] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            y_calc = sum_ext[DATA_WIDTH-1:0];
        end
`else
        y_calc = DATA_WIDTH'(ff_q + fb_q);
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= READ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        case (state)
            READ: begin
                // Gated by reset so no pop is signalled while reset is held.
                if (!x_in_empty && !reset) begin
                    x_in_rd_en = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    state_next  = READ;
                end
            end
            default: begin
                state_next = READ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // y_out doubles as the y[n] register: it is loaded at the end of
    // COMPUTE and stays put through any WRITE stall until pushed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_n   <= '0;
            x_n1  <= '0;
            y_n1  <= '0;
            y_out <= '0;
        end else begin
            case (state)
                READ: begin
                    if (x_in_rd_en) begin
                        x_n <= x_in;
                    end
                end
                COMPUTE: begin
                    y_out <= y_calc;
                end
                WRITE: begin
                    if (y_out_wr_en) begin
                        x_n1 <= x_n;
                        y_n1 <= y_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_deemph.sv
module tb_iir_deemph;

    localparam longint X0    = 178;
    localparam longint X1    = 178;
    localparam longint Y1    = 667;
    localparam longint SCALE = 1024;
    localparam longint SMAX  = 64'sd2147483647;
    localparam longint SMIN  = -64'sd2147483648;

    logic        clock;
    logic        reset;
    logic [31:0] x_in;
    logic        x_in_rd_en;
    logic        x_in_empty;
    logic [31:0] y_out;
    logic        y_out_wr_en;
    logic        y_out_full;

    logic [31:0] o_x_in;
    logic        o_rd_en;
    logic        o_empty;
    logic [31:0] o_y;
    logic        o_wr_en;
    logic        o_full;

    int checks;
    int errors;
    int cyc;

    // Bench-side FIFOs and reference state
    int          src[$];
    int          exp_x[$];
    logic [31:0] exp_y[$];
    logic [31:0] got[$];
    int          pop_cycs[$];
    int          push_cycs[$];
    int          mx1;
    int          my1;
    logic        last_rd;
    logic        last_wr;

    iir_deemph dut (
        .clock       (clock),
        .reset       (reset),
        .x_in        (x_in),
        .x_in_rd_en  (x_in_rd_en),
        .x_in_empty  (x_in_empty),
        .y_out       (y_out),
        .y_out_wr_en (y_out_wr_en),
        .y_out_full  (y_out_full)
    );

    iir_deemph #(
        .X_COEFF0 (4096)
    ) dut_ovf (
        .clock       (clock),
        .reset       (reset),
        .x_in        (o_x_in),
        .x_in_rd_en  (o_rd_en),
        .x_in_empty  (o_empty),
        .y_out       (o_y),
        .y_out_wr_en (o_wr_en),
        .y_out_full  (o_full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [31:0] ref_y(input longint x, input longint x1, input longint y1);
        longint s;
        s = floor_div(X0 * x + X1 * x1, SCALE) + floor_div(Y1 * y1, SCALE);
`ifdef IIR_DEEMPH_SATURATE_EN
        if (s > SMAX) return 32'h7FFF_FFFF;
        if (s < SMIN) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // One clock: drive at negedge, observe strobes 1 time unit later,
    // account pops/pushes against the reference, then advance.
    task automatic cycle(input bit want_empty, input bit full);
        x_in_empty = want_empty || (src.size() == 0);
        x_in       = (src.size() != 0) ? src[0] : 32'hDEAD_BEEF;
        y_out_full = full;
        #1;
        last_rd = x_in_rd_en;
        last_wr = y_out_wr_en;
        if (x_in_rd_en && y_out_wr_en) chk("pop_and_push", {x_in_rd_en, y_out_wr_en}, 2'b00);
        if (x_in_rd_en && x_in_empty)  chk("pop_when_empty", x_in_rd_en, 1'b0);
        if (y_out_wr_en && y_out_full) chk("push_when_full", y_out_wr_en, 1'b0);
        if (x_in_rd_en) begin
            int x;
            x = src.pop_front();
            exp_y.push_back(ref_y(x, mx1, my1));
            exp_x.push_back(x);
            pop_cycs.push_back(cyc);
        end
        if (y_out_wr_en) begin
            chk("push_expected", exp_y.size() != 0, 1'b1);
            if (exp_y.size() != 0) begin
                chk("y_out", y_out, exp_y[0]);
                mx1 = exp_x.pop_front();
                my1 = exp_y.pop_front();
            end
            got.push_back(y_out);
            push_cycs.push_back(cyc);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget, input bit stalls);
        for (int i = 0; i < budget && (src.size() != 0 || exp_y.size() != 0); i++) begin
            if (stalls) cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            else        cycle(1'b0, 1'b0);
        end
        chk({tag, "_drain"}, src.size() + exp_y.size(), 0);
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        x_in_empty = 1'b0;
        x_in       = 32'd1024;
        y_out_full = 1'b0;
        #1;
        chk("rst_y_out", y_out, 32'h0);
        chk("rst_rd_en", x_in_rd_en, 1'b0);
        chk("rst_wr_en", y_out_wr_en, 1'b0);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_hold_rd_en", x_in_rd_en, 1'b0);
        chk("rst_hold_y_out", y_out, 32'h0);
        reset = 1'b0;
        src.delete();
        exp_x.delete();
        exp_y.delete();
        got.delete();
        pop_cycs.delete();
        push_cycs.delete();
        mx1 = 0;
        my1 = 0;
    endtask

    initial begin
        bit seen;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        o_x_in     = 32'h0;
        o_empty    = 1'b1;
        o_full     = 1'b0;

        // Reset state
        apply_reset();

        // Positive impulse
        src = '{1024, 0, 0};
        drain("imp", 30, 1'b0);
        chk("imp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("imp_y0", got[0], 32'd178);
            chk("imp_y1", got[1], 32'd293);
            chk("imp_y2", got[2], 32'd190);
        end

        // Negative impulse (floor shift)
        apply_reset();
        src = '{-1024, 0};
        drain("neg", 30, 1'b0);
        chk("neg_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("neg_y0", got[0], 32'hFFFF_FF4E);   // -178
            chk("neg_y1", got[1], 32'hFFFF_FEDA);   // -294
        end

        // Back-pressure: COMPUTE then 5 stalled WRITE cycles
        apply_reset();
        src = '{1024};
        cycle(1'b0, 1'b1);
        chk("bp_popped", pop_cycs.size(), 1);
        src.push_back(0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            chk("bp_hold_wr", last_wr, 1'b0);
            chk("bp_hold_rd", last_rd, 1'b0);
        end
        cycle(1'b0, 1'b0);
        chk("bp_push", last_wr, 1'b1);
        chk("bp_push_once", got.size(), 1);
        if (got.size() != 0) chk("bp_y0", got[0], 32'd178);
        drain("bp", 30, 1'b0);
        chk("bp_total", got.size(), 2);

        // Randomised starvation / back-pressure
        apply_reset();
        for (int i = 0; i < 100; i++) src.push_back(int'($urandom()));
        drain("rand", 4000, 1'b1);
        chk("rand_count", got.size(), 100);

        // Throughput with no stalls: pop->push 2 cycles, push every 3
        got.delete();
        pop_cycs.delete();
        push_cycs.delete();
        for (int i = 0; i < 10; i++) src.push_back(int'($urandom_range(0, 65535)) - 32768);
        drain("tput", 100, 1'b0);
        chk("tput_count", push_cycs.size(), 10);
        for (int i = 0; i < push_cycs.size() && i < pop_cycs.size(); i++) begin
            chk("tput_latency", push_cycs[i] - pop_cycs[i], 2);
            if (i > 0) chk("tput_interval", push_cycs[i] - push_cycs[i-1], 3);
        end

        // Reset mid-WRITE while downstream is full
        apply_reset();
        src = '{777};
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        chk("midrst_no_push", got.size(), 0);
        apply_reset();
        src = '{1024};
        drain("midrst", 30, 1'b0);
        chk("midrst_count", got.size(), 1);
        if (got.size() != 0) chk("midrst_y0", got[0], 32'd178);

        // Overflow instance (X_COEFF0 = 4096)
        x_in_empty = 1'b1;
        o_x_in     = 32'h4000_0000;
        o_empty    = 1'b0;
        #1;
        chk("ovf_pop", o_rd_en, 1'b1);
        @(posedge clock);
        @(negedge clock);
        o_empty = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            #1;
            if (o_wr_en) begin
`ifdef IIR_DEEMPH_SATURATE_EN
                chk("ovf_y", o_y, 32'h7FFF_FFFF);
`else
                chk("ovf_y", o_y, 32'h0000_0000);
`endif
                seen = 1'b1;
            end
            @(posedge clock);
            @(negedge clock);
        end
        chk("ovf_push_seen", seen, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
